// File: rtl/div_pkg.sv
// Shared constants for the divider issuer: FSM encoding, default sizing, div-by-zero result.
// Latency: n/a (package only).
// Backpressure: n/a.
package div_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ISSUE = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_RESP  = 3'd3;
    localparam state_t S_GAP   = 3'd4;

    // Quotient reported for a zero divisor; wide enough for any WIDTH up to 64, sliced by users.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_req_fifo.sv
// Request buffer: DEPTH-entry synchronous FIFO holding {dividend, divisor} pairs.
// Latency: a push is visible at the head (o_empty low) on the cycle after it is written.
// Backpressure: o_full blocks pushes; a pop while full frees the slot only from the next cycle.
module div_req_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_dat,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_dat   = r_mem[r_rptr];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_dat;
    end

endmodule

// File: rtl/div_issuer.sv
// Divider front end: buffers requests, runs one divide at a time, returns results in order.
// Latency: push->pop 1, pop->start 1, done sampled at N -> out_valid at N+1; div-by-zero push->valid 2.
// Backpressure: in_ready = FIFO not full; a held out_valid stalls the FSM and fills the FIFO.
module div_issuer
    import div_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_by_zero,
    output logic             out_timeout,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT);
    // Elapsed cycles since ISSUE is r_cnt+1 in WAIT; giving up at TIMEOUT-1 elapsed
    // puts the aborted response on out_valid exactly TIMEOUT cycles after the start pulse.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_div_dividend;
    logic [WIDTH-1:0]  r_div_divisor;
    logic [WIDTH-1:0]  r_out_q;
    logic [WIDTH-1:0]  r_out_r;
    logic              r_dbz;
    logic              r_to;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0]  w_head_dividend;
    logic [WIDTH-1:0]  w_head_divisor;
    logic              w_head_div0;
    logic              w_push;
    logic              w_pop;
    logic              w_done_ok;
    logic              w_expired;

    assign in_ready        = !w_fifo_full;
    assign w_push          = in_valid && !w_fifo_full;
    assign w_pop           = (r_state == S_IDLE) && !w_fifo_empty;
    assign w_head_dividend = w_head[2*WIDTH-1:WIDTH];
    assign w_head_divisor  = w_head[WIDTH-1:0];
    assign w_head_div0     = (w_head_divisor == '0);
    // A done seen in the first WAIT cycle may be left over from the previous divide.
    assign w_done_ok       = (r_state == S_WAIT) && div_done && (r_cnt != '0);
    assign w_expired       = (r_state == S_WAIT) && (r_cnt == CNT_LAST);

    assign div_dividend    = r_div_dividend;
    assign div_divisor     = r_div_divisor;
    assign out_quotient    = r_out_q;
    assign out_remainder   = r_out_r;
    assign out_div_by_zero = r_dbz;
    assign out_timeout     = r_to;

    div_req_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_dat   ({in_dividend, in_divisor}),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state selection; done takes priority over the timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_fifo_empty) w_state_nxt = w_head_div0 ? S_RESP : S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done_ok || w_expired) w_state_nxt = S_RESP;
            S_RESP:  if (out_ready) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; all derive from registers so reset clears them at once.
    always_comb begin
        div_start = (r_state == S_ISSUE);
        out_valid = (r_state == S_RESP);
        busy      = (r_state != S_IDLE) || !w_fifo_empty;
    end

    // Operand, wait-counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_out_q        <= '0;
            r_out_r        <= '0;
            r_dbz          <= 1'b0;
            r_to           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_div_dividend <= w_head_dividend;
                        r_div_divisor  <= w_head_divisor;
                        r_dbz          <= 1'b0;
                        r_to           <= 1'b0;
                        if (w_head_div0) begin
                            r_out_q <= DIV0_QUOTIENT[WIDTH-1:0];
                            r_out_r <= w_head_dividend;
                            r_dbz   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_done_ok) begin
                        r_out_q <= div_quotient;
                        r_out_r <= div_remainder;
                    end else if (w_expired) begin
                        r_out_q <= '0;
                        r_out_r <= '0;
                        r_to    <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_dbz <= 1'b0;
                        r_to  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issuer.sv
// Bench for div_issuer: divider model, transaction-level reference queue, per-cycle output compare.
// Latency: n/a.
// Backpressure: out_ready is driven both held-low and randomly toggled.
module tb_div_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        out_div_by_zero;
    logic        out_timeout;
    logic        busy;

    div_issuer #(.WIDTH(32), .DEPTH(4), .TIMEOUT(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .div_start       (div_start),
        .div_dividend    (div_dividend),
        .div_divisor     (div_divisor),
        .div_done        (div_done),
        .div_quotient    (div_quotient),
        .div_remainder   (div_remainder),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_quotient    (out_quotient),
        .out_remainder   (out_remainder),
        .out_div_by_zero (out_div_by_zero),
        .out_timeout     (out_timeout),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // ---------------- divider model ----------------
    // Done is a level that stays high until one cycle after the next start (stale done).
    int fixed_lat    = 34;
    int hang_tok_div = 0;
    int hang_tok_ref = 0;
    int div_hang_used;
    int div_cnt;
    logic        div_pend;
    logic [31:0] opa, opb;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_done      <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
            div_pend      <= 1'b0;
            div_cnt       <= 0;
            div_hang_used <= 0;
            opa           <= '0;
            opb           <= '0;
        end else begin
            if (div_pend) begin
                div_done <= 1'b0;
                div_pend <= 1'b0;
            end
            if (div_start) begin
                div_pend <= 1'b1;
                opa      <= div_dividend;
                opb      <= div_divisor;
                if (div_hang_used < hang_tok_div) begin
                    div_hang_used <= div_hang_used + 1;
                    div_cnt       <= 0;
                end else begin
                    div_cnt <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 40));
                end
            end else if (div_cnt != 0) begin
                div_cnt <= div_cnt - 1;
                if (div_cnt == 1) begin
                    div_done      <= 1'b1;
                    div_quotient  <= (opb == 0) ? 32'hFFFF_FFFF : opa / opb;
                    div_remainder <= (opb == 0) ? opa : opa % opb;
                end
            end
        end
    end

    // ---------------- reference model and compare ----------------
    typedef struct {
        logic [31:0] a, b, q, r;
        logic        dz, to;
        int          acc;
    } exp_t;

    exp_t expq[$];
    logic [31:0] hq[$], hr[$];
    logic        hdz[$], hto[$];
    int          hlat_s[$], hlat_a[$];
    int  ref_hang_used = 0;
    int  acc_cnt = 0, resp_cnt = 0, n_start = 0;
    int  last_start_cyc = 0, last_hs_cyc = 0, rise_cyc = 0, start_lat = 0;
    logic [31:0] last_start_a = '0, last_start_b = '0;
    bit  gap_arm = 0, prev_valid = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t f;
        if (!rst) begin
            expq.delete();
            ref_hang_used = 0;
            gap_arm       = 0;
            prev_valid    = 0;
        end else begin
            if (in_valid && in_ready) begin
                e.a   = in_dividend;
                e.b   = in_divisor;
                e.acc = cyc;
                e.dz  = 1'b0;
                e.to  = 1'b0;
                if (e.b == 0) begin
                    e.q  = 32'hFFFF_FFFF;
                    e.r  = e.a;
                    e.dz = 1'b1;
                end else if (ref_hang_used < hang_tok_ref) begin
                    ref_hang_used++;
                    e.q  = 0;
                    e.r  = 0;
                    e.to = 1'b1;
                end else begin
                    e.q = e.a / e.b;
                    e.r = e.a % e.b;
                end
                expq.push_back(e);
                acc_cnt++;
            end
            if (div_start) begin
                n_start++;
                last_start_cyc = cyc;
                last_start_a   = div_dividend;
                last_start_b   = div_divisor;
                if (expq.size() == 0) fail_now("start_without_request");
                else begin
                    check("start_dividend", div_dividend, expq[0].a);
                    check("start_divisor", div_divisor, expq[0].b);
                    start_lat = cyc - expq[0].acc;
                end
                if (gap_arm) check("gap_handshake_to_start", cyc - last_hs_cyc, 3);
                gap_arm = 0;
            end
            if (out_valid) begin
                if (!prev_valid) rise_cyc = cyc;
                if (expq.size() == 0) fail_now("out_valid_without_request");
                else begin
                    check("out_quotient", out_quotient, expq[0].q);
                    check("out_remainder", out_remainder, expq[0].r);
                    check("out_div_by_zero", out_div_by_zero, expq[0].dz);
                    check("out_timeout", out_timeout, expq[0].to);
                    check("busy_in_resp", busy, 1);
                    if (out_ready) begin
                        f = expq.pop_front();
                        hq.push_back(out_quotient);
                        hr.push_back(out_remainder);
                        hdz.push_back(out_div_by_zero);
                        hto.push_back(out_timeout);
                        hlat_s.push_back(rise_cyc - last_start_cyc);
                        hlat_a.push_back(rise_cyc - f.acc);
                        resp_cnt++;
                        last_hs_cyc = cyc;
                        gap_arm = (expq.size() > 0) && (expq[0].b != 0);
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic try_push(input logic [31:0] a, input logic [31:0] b, input int budget, output bit ok);
        int k;
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        ok = 0;
        k  = 0;
        @(negedge clk);
        while (!in_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        try_push(a, b, 500, ok);
        if (!ok) fail_now("push_accept_timeout");
    endtask

    task automatic wait_resp(input int target, input int budget);
        int k;
        k = 0;
        while (resp_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (resp_cnt < target) fail_now("response_wait_timeout");
    endtask

    task automatic wait_start_high(input int budget);
        int k;
        k = 0;
        while (!div_start && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!div_start) fail_now("start_wait_timeout");
    endtask

    task automatic release_reset();
        hang_tok_div = 0;
        hang_tok_ref = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_div_start"}, div_start, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_timeout"}, out_timeout, 0);
        check({tag, "_out_div_by_zero"}, out_div_by_zero, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin : stim
        int b0, s0, a0;
        bit ok;
        logic [31:0] ra, rb;
        int sent;
        bit drop;

        rst = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; out_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        check("reset_out_quotient", out_quotient, 0);
        check("reset_out_remainder", out_remainder, 0);
        check("reset_div_dividend", div_dividend, 0);
        release_reset();

        // single request, 34-cycle divider
        b0 = resp_cnt; s0 = n_start;
        push(10, 7);
        wait_resp(b0 + 1, 300);
        repeat (4) @(posedge clk);
        #1;
        check("t1_start_count", n_start - s0, 1);
        check("t1_start_dividend", last_start_a, 10);
        check("t1_start_divisor", last_start_b, 7);
        check("t1_push_to_start", start_lat, 2);
        check("t1_q", hq[b0], 1);
        check("t1_r", hr[b0], 3);
        check("t1_flags", {hdz[b0], hto[b0]}, 0);

        // back-to-back requests
        b0 = resp_cnt;
        push(100, 100); push(100, 7); push(70, 150);
        wait_resp(b0 + 3, 600);
        check("t2_q0", hq[b0], 1);       check("t2_r0", hr[b0], 0);
        check("t2_q1", hq[b0+1], 14);    check("t2_r1", hr[b0+1], 2);
        check("t2_q2", hq[b0+2], 0);     check("t2_r2", hr[b0+2], 70);

        // divide by zero
        repeat (3) @(posedge clk);
        #1;
        b0 = resp_cnt; s0 = n_start;
        push(100, 0);
        wait_resp(b0 + 1, 50);
        check("t3_q", hq[b0], 32'hFFFF_FFFF);
        check("t3_r", hr[b0], 100);
        check("t3_dz", hdz[b0], 1);
        check("t3_no_start", n_start - s0, 0);
        check("t3_push_to_valid", hlat_a[b0], 2);

        // FIFO fill with result held
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        b0 = resp_cnt; a0 = acc_cnt;
        for (int i = 0; i < 5; i++) push(32'(1000 + 37 * i), 32'(i + 3));
        try_push(5555, 11, 60, ok);
        check("t4_sixth_rejected", ok, 0);
        check("t4_accepted", acc_cnt - a0, 5);
        check("t4_in_ready_full", in_ready, 0);
        check("t4_held_no_resp", resp_cnt - b0, 0);
        check("t4_held_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_resp(b0 + 5, 800);
        check("t4_first_q", hq[b0], 333);
        check("t4_first_r", hr[b0], 1);

        // hung divider -> timeout, then a normal request
        repeat (3) @(posedge clk);
        #1;
        hang_tok_div = div_hang_used + 1;
        hang_tok_ref = ref_hang_used + 1;
        b0 = resp_cnt;
        push(50, 5); push(9, 4);
        wait_resp(b0 + 2, 600);
        check("t5_timeout_flag", hto[b0], 1);
        check("t5_timeout_q", hq[b0], 0);
        check("t5_timeout_r", hr[b0], 0);
        check("t5_start_to_valid", hlat_s[b0], 64);
        check("t5_next_q", hq[b0+1], 2);
        check("t5_next_r", hr[b0+1], 1);
        check("t5_next_flag", hto[b0+1], 0);

        // reset during the start pulse
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; in_dividend = 77; in_divisor = 5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_start_high(20);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_issue");
        release_reset();

        // reset mid-WAIT
        push(123, 4);
        wait_start_high(20);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        release_reset();
        b0 = resp_cnt;
        push(100, 7);
        wait_resp(b0 + 1, 300);
        check("t6_q", hq[b0], 14);
        check("t6_r", hr[b0], 2);

        // randomized traffic with random divider latency and random out_ready
        fixed_lat = 0;
        b0 = resp_cnt; a0 = acc_cnt;
        sent = 0; drop = 0;
        for (int c = 0; c < 20000 && sent < 60; c++) begin
            @(posedge clk);
            #1;
            if (drop) begin in_valid = 1'b0; drop = 0; end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
                case ($urandom_range(0, 7))
                    0:       rb = 0;
                    1:       rb = $urandom;
                    2:       rb = 1;
                    default: rb = 32'($urandom_range(1, 50));
                endcase
                in_dividend = ra; in_divisor = rb; in_valid = 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin sent++; drop = 1; end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", sent, 60);
        wait_resp(b0 + (acc_cnt - a0), 5000);
        repeat (4) @(posedge clk);
        #1;
        check("end_queue_empty", expq.size(), 0);
        check("end_busy", busy, 0);
        check("end_out_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
